run_timer: RTL and testbench

Run timer and best-time keeper, directly downstream of the game-end logic. Consumes `gamestart`, `gameover` and `complete`. Measures elapsed play time as a BCD count from game start to game over. Retains the fastest completed run for the HEX display driver.

---
 rtl/run_timer_pkg.sv | 17 +
 rtl/bcd_counter.sv | 69 ++++++
 rtl/run_timer.sv | 134 +++++++++++++
 tb/tb_run_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/run_timer_pkg.sv
// Shared types and constants for the run timer.
// The RUN_TIMER_BEST_EN macro, used in run_timer.sv, enables best-time tracking.
package run_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } run_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage : run_timer_pkg

// File: rtl/bcd_counter.sv
// Chained multi-digit BCD incrementer with synchronous clear.
// At all-9s it holds the count and raises a sticky saturate flag.
module bcd_counter
    import run_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count,
    output logic                  saturated
);

    bcd_digit_t [DIGITS-1:0] cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic                    all_max_c;
    logic                    carry_c;

    always_comb begin
        all_max_c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (cnt_q[i] != BCD_MAX) begin
                all_max_c = 1'b0;
            end
        end
    end

    // Ripple the increment upward until a digit absorbs it.
    always_comb begin
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        carry_c = inc;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (all_max_c) begin
                sat_d = 1'b1;
            end else begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (carry_c) begin
                        if (cnt_q[i] == BCD_MAX) begin
                            cnt_d[i] = 4'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            carry_c  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign count     = cnt_q;
    assign saturated = sat_q;

endmodule : bcd_counter

// File: rtl/run_timer.sv
// Run timer: FSM, tick prescaler, BCD run-time count and best-time register.
// Define RUN_TIMER_BEST_EN to build best-time tracking; otherwise best outputs are 0.
module run_timer
    import run_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gamestart,
    input  logic                  gameover,
    input  logic                  complete,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic                  best_valid,
    output logic                  new_record,
    output logic                  running,
    output logic                  saturated
);

    localparam int unsigned W   = 4 * DIGITS;
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    run_state_t      state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            running_q, running_d;
    logic            tick_c;
    logic            win_c;
    logic [W-1:0]    cnt_bcd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= running_d;
        end
    end

    // gamestart dominates everything; a stop in RUN discards a coincident tick.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_c  = 1'b0;
        win_c   = 1'b0;
        if (gamestart) begin
            state_d = ARMED;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    presc_d = '0;
                    if (!gameover) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (gameover) begin
                        state_d = complete ? WIN : LOSE;
                        win_c   = complete;
                    end else if (presc_q == PW'(DIV - 1)) begin
                        presc_d = '0;
                        tick_c  = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_bcd_counter (
        .clk       (clk),
        .rst_n     (reset),
        .clr       (gamestart),
        .inc       (tick_c),
        .count     (cnt_bcd),
        .saturated (saturated)
    );

    assign time_bcd = cnt_bcd;
    assign running  = running_q;

`ifdef RUN_TIMER_BEST_EN
    logic [W-1:0] best_q, best_d;
    logic         best_valid_q, best_valid_d;
    logic         new_record_q, new_record_d;

    // Equal-width BCD compares correctly as plain unsigned binary.
    always_comb begin
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_record_d = 1'b0;
        if (win_c && (!best_valid_q || (cnt_bcd < best_q))) begin
            best_d       = cnt_bcd;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q       <= '0;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_record_q <= new_record_d;
        end
    end

    assign best_bcd   = best_q;
    assign best_valid = best_valid_q;
    assign new_record = new_record_q;
`else
    logic unused_win;
    assign unused_win = win_c;
    assign best_bcd   = '0;
    assign best_valid = 1'b0;
    assign new_record = 1'b0;
`endif

endmodule : run_timer

// File: tb/tb_run_timer.sv
// Self-checking bench for run_timer against a decimal-arithmetic reference model.
// Honours RUN_TIMER_BEST_EN the same way as the design.
module tb_run_timer;

    localparam int unsigned CLK_HZ  = 10;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned DIGITS  = 2;
    localparam int          DIV     = CLK_HZ / TICK_HZ;
    localparam int          MAXV    = 99;

    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_WIN = 3, M_LOSE = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                gamestart, gameover, complete;
    logic [4*DIGITS-1:0] time_bcd, best_bcd;
    logic                best_valid, new_record, running, saturated;

    int n_vec = 0;
    int n_err = 0;

    int m_st, m_time, m_presc, m_best;
    bit m_sat, m_valid, m_newrec, m_running;

    run_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .DIGITS  (DIGITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gamestart  (gamestart),
        .gameover   (gameover),
        .complete   (complete),
        .time_bcd   (time_bcd),
        .best_bcd   (best_bcd),
        .best_valid (best_valid),
        .new_record (new_record),
        .running    (running),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_st = M_IDLE; m_time = 0; m_presc = 0; m_best = 0;
        m_sat = 0; m_valid = 0; m_newrec = 0; m_running = 0;
    endfunction

    // One clock of behaviour, from the inputs sampled at the edge.
    function automatic void model_step(input bit gs, input bit go, input bit cp);
        m_newrec = 0;
        if (gs) begin
            m_st = M_ARMED; m_time = 0; m_presc = 0; m_sat = 0;
        end else if (m_st == M_ARMED) begin
            if (!go) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (go && cp) begin
                m_st = M_WIN;
                if (!m_valid || m_time < m_best) begin
                    m_best = m_time; m_valid = 1; m_newrec = 1;
                end
            end else if (go) begin
                m_st = M_LOSE;
            end else if (m_presc == DIV - 1) begin
                m_presc = 0;
                if (m_time == MAXV) m_sat = 1;
                else m_time++;
            end else begin
                m_presc++;
            end
        end
        m_running = (m_st == M_RUN);
    endfunction

    task automatic check_all();
        chk("time_bcd", 32'(time_bcd), 32'(to_bcd(m_time)));
        chk("running", 32'(running), 32'(m_running));
        chk("saturated", 32'(saturated), 32'(m_sat));
`ifdef RUN_TIMER_BEST_EN
        chk("best_bcd", 32'(best_bcd), 32'(m_valid ? to_bcd(m_best) : '0));
        chk("best_valid", 32'(best_valid), 32'(m_valid));
        chk("new_record", 32'(new_record), 32'(m_newrec));
`else
        chk("best_bcd", 32'(best_bcd), 32'h0);
        chk("best_valid", 32'(best_valid), 32'h0);
        chk("new_record", 32'(new_record), 32'h0);
`endif
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next falling edge.
    task automatic cyc(input bit gs, input bit go, input bit cp);
        gamestart = gs; gameover = go; complete = cp;
        @(posedge clk);
        model_step(gs, go, cp);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_for(input int n_cycles, input bit cp);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        repeat (n_cycles) cyc(0, 0, 0);
        cyc(0, 1, cp);
    endtask

    initial begin
        reset = 1'b0; gamestart = 1'b0; gameover = 1'b0; complete = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 1, 1);

        // Start, then 03 after 30 counted cycles.
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("running_after_start", 32'(running), 32'h1);
        repeat (30) cyc(0, 0, 0);
        chk("time_at_30", 32'(time_bcd), 32'h03);

        // Saturation after 125 ticks, then a winning stop.
        repeat (125 * DIV - 30) cyc(0, 0, 0);
        cyc(0, 1, 1);
        chk("sat_time", 32'(time_bcd), 32'h99);
        chk("sat_flag", 32'(saturated), 32'h1);
`ifdef RUN_TIMER_BEST_EN
        chk("sat_best", 32'(best_bcd), 32'h99);
        chk("sat_pulse", 32'(new_record), 32'h1);
`endif
        cyc(0, 0, 0);
        chk("pulse_one_cycle", 32'(new_record), 32'h0);

        // Record sequence 12 -> 09 -> 09.
        run_for(12 * DIV, 1);
        chk("rec12_time", 32'(time_bcd), 32'h12);
        run_for(9 * DIV, 1);
`ifdef RUN_TIMER_BEST_EN
        chk("rec09_best", 32'(best_bcd), 32'h09);
        chk("rec09_pulse", 32'(new_record), 32'h1);
`endif
        run_for(9 * DIV, 1);
        chk("eq09_nopulse", 32'(new_record), 32'h0);

        // Losing run at 05.
        run_for(5 * DIV, 0);
        chk("lose_time", 32'(time_bcd), 32'h05);
        chk("lose_nopulse", 32'(new_record), 32'h0);
        repeat (15) cyc(0, 0, 0);
        chk("lose_hold", 32'(time_bcd), 32'h05);

        // Stop on the tick cycle discards that tick.
        run_for(3 * DIV - 1, 0);
        chk("stop_beats_tick", 32'(time_bcd), 32'h02);

        // gamestart and gameover together during RUN.
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        repeat (25) cyc(0, 0, 0);
        cyc(1, 1, 0);
        chk("start_wins_time", 32'(time_bcd), 32'h00);
        chk("start_wins_run", 32'(running), 32'h0);
        cyc(0, 1, 0);
        chk("armed_hold", 32'(running), 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1);
        end

        // Ensure a recorded best, then reset mid-run between clock edges.
        run_for(4 * DIV, 1);
        cyc(1, 0, 0);
        repeat (DIV + 3) cyc(0, 0, 0);
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_time", 32'(time_bcd), 32'h0);
        chk("rst_best", 32'(best_bcd), 32'h0);
        chk("rst_valid", 32'(best_valid), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_sat", 32'(saturated), 32'h0);
        chk("rst_pulse", 32'(new_record), 32'h0);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_run_timer
